// File: rtl/util_upack2_timestamp.sv
// util_upack2_timestamp: timestamped TX unpacker between DMA FIFO and DAC.
// Frames wait until the DAC time matches their header, late ones are dropped.
module util_upack2_timestamp #(
  parameter int NUM_OF_CHANNELS   = 4,
  parameter int SAMPLE_DATA_WIDTH = 16,
  parameter int LATE_COUNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [63:0]                  timestamp,
  input  logic [31:0]                  timestamp_every,
  input  logic                         enable_0,
  input  logic                         enable_1,
  input  logic                         enable_2,
  input  logic                         enable_3,
  input  logic                         fifo_rd_en,
  output logic                         fifo_rd_valid,
  output logic                         fifo_rd_underflow,
  output logic [SAMPLE_DATA_WIDTH-1:0] fifo_rd_data_0,
  output logic [SAMPLE_DATA_WIDTH-1:0] fifo_rd_data_1,
  output logic [SAMPLE_DATA_WIDTH-1:0] fifo_rd_data_2,
  output logic [SAMPLE_DATA_WIDTH-1:0] fifo_rd_data_3,
  output logic                         packed_fifo_rd_en,
  input  logic                         packed_fifo_rd_valid,
  input  logic [63:0]                  packed_fifo_rd_data,
  output logic                         late,
  output logic [LATE_COUNT_WIDTH-1:0]  late_count
);

  localparam int SW = SAMPLE_DATA_WIDTH;
  localparam int NL = NUM_OF_CHANNELS;
  localparam int BW = 2 * NL * SW;
  localparam logic [3:0] OCC_HALF = 4'(NL);

  typedef enum logic [1:0] {
    FETCH_HDR,
    WAIT_TS,
    STREAM,
    DISCARD
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0] buf_q, buf_d, buf_pop;
  logic [3:0]    occ_q, occ_d, occ_pop;
  logic [63:0]   hdr_q;
  logic [32:0]   rem_q;
  logic [31:0]   set_cnt_q;

  logic          valid_q, uf_q, late_q;
  logic [SW-1:0] data_q [NL];
  logic [SW-1:0] set_d  [NL];
  logic [LATE_COUNT_WIDTH-1:0] late_count_q;

  logic [3:0]  en;
  logic [2:0]  n_en;
  logic        active;
  logic [31:0] every_eff;
  logic [34:0] lanes_tot;
  logic [32:0] words;
  logic        last_set;
  logic        can_fill;

  logic acc, xfer, push, pop, clr;
  logic ld_hdr, late_d, rd, uf_d;
  logic [1:0] pos;

  assign en = {enable_3, enable_2, enable_1, enable_0};

  always_comb begin
    n_en = '0;
    for (int c = 0; c < NL; c++) begin
      n_en = n_en + {2'b0, en[c]};
    end
  end

  assign active    = (n_en != '0);
  assign every_eff = (timestamp_every == '0) ? 32'd1 : timestamp_every;
  assign lanes_tot = {3'b0, every_eff} * {32'b0, n_en};
  assign words     = lanes_tot[34:2] + {32'b0, |lanes_tot[1:0]};
  assign last_set  = (set_cnt_q + 32'd1) == every_eff;
  assign can_fill  = active && (occ_q <= OCC_HALF) && (rem_q != '0);

  assign xfer = acc && packed_fifo_rd_valid;
  assign push = xfer && ((state_q == WAIT_TS) || (state_q == STREAM));

  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    clr     = 1'b0;
    ld_hdr  = 1'b0;
    late_d  = 1'b0;
    rd      = 1'b0;
    uf_d    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      FETCH_HDR: begin
        acc  = active;
        uf_d = 1'b1;
        if (acc && packed_fifo_rd_valid) begin
          ld_hdr  = 1'b1;
          state_d = (&packed_fifo_rd_data) ? STREAM : WAIT_TS;
        end
      end
      WAIT_TS: begin
        acc = can_fill;
        if (timestamp > hdr_q) begin
          state_d = DISCARD;
          late_d  = 1'b1;
          clr     = 1'b1;
          uf_d    = 1'b1;
        end else if (timestamp == hdr_q) begin
          rd = 1'b1;
        end
      end
      STREAM: begin
        acc = can_fill;
        rd  = 1'b1;
      end
      DISCARD: begin
        acc  = active && (rem_q != '0);
        uf_d = 1'b1;
        if (rem_q == '0) begin
          clr     = 1'b1;
          state_d = FETCH_HDR;
        end
      end
      default: state_d = FETCH_HDR;
    endcase
    if (rd && fifo_rd_en) begin
      state_d = STREAM;
      if (occ_q >= {1'b0, n_en}) begin
        pop = 1'b1;
        if (last_set) begin
          clr     = 1'b1;
          state_d = FETCH_HDR;
        end
      end else begin
        uf_d = 1'b1;
      end
    end
  end

  // lanes above the occupancy are always zero, so a push is a shifted OR
  always_comb begin
    buf_pop = pop ? (buf_q >> (n_en * SW)) : buf_q;
    occ_pop = pop ? (occ_q - {1'b0, n_en}) : occ_q;
    buf_d   = buf_pop;
    occ_d   = occ_pop;
    if (push) begin
      buf_d = buf_pop |
        ({{(BW-64){1'b0}}, packed_fifo_rd_data} << (occ_pop * SW));
      occ_d = occ_pop + OCC_HALF;
    end
    if (clr) begin
      buf_d = '0;
      occ_d = '0;
    end
  end

  always_comb begin
    pos = '0;
    for (int c = 0; c < NL; c++) begin
      set_d[c] = en[c] ? buf_q[pos*SW +: SW] : '0;
      pos = pos + {1'b0, en[c]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH_HDR;
      buf_q        <= '0;
      occ_q        <= '0;
      hdr_q        <= '0;
      rem_q        <= '0;
      set_cnt_q    <= '0;
      valid_q      <= 1'b0;
      uf_q         <= 1'b0;
      late_q       <= 1'b0;
      late_count_q <= '0;
      for (int c = 0; c < NL; c++) begin
        data_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      occ_q   <= occ_d;
      if (ld_hdr) begin
        hdr_q     <= packed_fifo_rd_data;
        rem_q     <= words;
        set_cnt_q <= '0;
      end else if (xfer) begin
        rem_q <= rem_q - 33'd1;
      end
      if (pop) begin
        set_cnt_q <= set_cnt_q + 32'd1;
      end
      valid_q <= fifo_rd_en;
      uf_q    <= fifo_rd_en && uf_d;
      if (fifo_rd_en) begin
        for (int c = 0; c < NL; c++) begin
          data_q[c] <= pop ? set_d[c] : '0;
        end
      end
      late_q <= late_d;
      if (late_d && !(&late_count_q)) begin
        late_count_q <= late_count_q + 1'b1;
      end
    end
  end

  assign packed_fifo_rd_en = acc;
  assign fifo_rd_valid     = valid_q;
  assign fifo_rd_underflow = uf_q;
  assign fifo_rd_data_0    = data_q[0];
  assign fifo_rd_data_1    = data_q[1];
  assign fifo_rd_data_2    = data_q[2];
  assign fifo_rd_data_3    = data_q[3];
  assign late              = late_q;
  assign late_count        = late_count_q;

endmodule

// File: tb/tb_util_upack2_timestamp.sv
// Bench for util_upack2_timestamp: frames are packed from per-set samples,
// expected sets are queued and matched by a monitor against the DAC side.
module tb_util_upack2_timestamp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] timestamp = '0;
  logic [31:0] timestamp_every = 32'd1;
  logic [3:0]  en = 4'b1111;
  logic        fifo_rd_en = 1'b0;
  logic        fifo_rd_valid;
  logic        fifo_rd_underflow;
  logic [15:0] fifo_rd_data_0, fifo_rd_data_1;
  logic [15:0] fifo_rd_data_2, fifo_rd_data_3;
  logic        packed_fifo_rd_en;
  logic        packed_fifo_rd_valid = 1'b0;
  logic [63:0] packed_fifo_rd_data = '0;
  logic        late;
  logic [31:0] late_count;

  always #5 clk = ~clk;

  util_upack2_timestamp dut (
    .clk                 (clk),
    .reset               (reset),
    .timestamp           (timestamp),
    .timestamp_every     (timestamp_every),
    .enable_0            (en[0]),
    .enable_1            (en[1]),
    .enable_2            (en[2]),
    .enable_3            (en[3]),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_valid       (fifo_rd_valid),
    .fifo_rd_underflow   (fifo_rd_underflow),
    .fifo_rd_data_0      (fifo_rd_data_0),
    .fifo_rd_data_1      (fifo_rd_data_1),
    .fifo_rd_data_2      (fifo_rd_data_2),
    .fifo_rd_data_3      (fifo_rd_data_3),
    .packed_fifo_rd_en   (packed_fifo_rd_en),
    .packed_fifo_rd_valid(packed_fifo_rd_valid),
    .packed_fifo_rd_data (packed_fifo_rd_data),
    .late                (late),
    .late_count          (late_count)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        first;
    logic [63:0] hdr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ts_q[$];
  logic [63:0] up_q[$];
  logic [63:0] ts = '0;
  logic [63:0] all_ones = '1;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_pct = 100;
  logic stall = 1'b0;
  int uf_mid = 0;
  int late_hi = 0;
  logic last_uf = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // upstream DMA FIFO model
  initial begin
    logic took;
    forever begin
      @(negedge clk);
      took = packed_fifo_rd_en && packed_fifo_rd_valid && !reset;
      @(posedge clk);
      #1;
      if (took && up_q.size() > 0) void'(up_q.pop_front());
      if (up_q.size() > 0 && !stall &&
          int'($urandom_range(99)) < valid_pct) begin
        packed_fifo_rd_valid = 1'b1;
        packed_fifo_rd_data  = up_q[0];
      end else begin
        packed_fifo_rd_valid = 1'b0;
        packed_fifo_rd_data  = '0;
      end
    end
  end

  // monitor: every valid output answers one strobe
  initial begin
    logic [63:0] act, t;
    exp_t e;
    forever begin
      @(negedge clk);
      if (late) late_hi++;
      if (fifo_rd_valid) begin
        act = {fifo_rd_data_3, fifo_rd_data_2,
               fifo_rd_data_1, fifo_rd_data_0};
        if (ts_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray_valid: got valid, required none");
        end else begin
          t = ts_q.pop_front();
          last_uf = fifo_rd_underflow;
          if (fifo_rd_underflow) begin
            if (exp_q.size() > 0 && !exp_q[0].first) uf_mid++;
            check("underflow_zero", act, 64'd0);
          end else if (act == '0) begin
            if (exp_q.size() == 0) begin
              check("wait_without_frame", 64'd1, 64'd0);
            end else begin
              check("wait_before_hdr",
                    64'(exp_q[0].first && exp_q[0].hdr != all_ones &&
                        t < exp_q[0].hdr), 64'd1);
            end
          end else if (exp_q.size() == 0) begin
            check("unexpected_set", act, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("set_data", act, e.d);
            if (e.first && e.hdr != all_ones) check("set_time", t, e.hdr);
          end
        end
      end
    end
  end

  task automatic do_reset(input logic [3:0] e, input int every);
    fifo_rd_en = 1'b0;
    reset = 1'b1;
    en = e;
    timestamp_every = 32'(every);
    stall = 1'b0;
    up_q.delete();
    exp_q.delete();
    ts_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(fifo_rd_valid), 64'd0);
    check("rst_underflow", 64'(fifo_rd_underflow), 64'd0);
    check("rst_data", {fifo_rd_data_3, fifo_rd_data_2,
                       fifo_rd_data_1, fifo_rd_data_0}, 64'd0);
    check("rst_late", 64'(late) + 64'(late_count), 64'd0);
    check("rst_packed_rd_en", 64'(packed_fifo_rd_en), 64'(e != 4'd0));
    reset = 1'b0;
  endtask

  // builds one frame: header word plus densely packed enabled lanes
  task automatic add_frame(input logic [63:0] hdr, input bit expect_out,
                           input bit directed, inout int base);
    logic [15:0] lanes[$];
    exp_t e;
    logic [15:0] v;
    int ev;
    ev = (timestamp_every == 0) ? 1 : int'(timestamp_every);
    up_q.push_back(hdr);
    for (int s = 0; s < ev; s++) begin
      e.d = '0;
      e.first = (s == 0);
      e.hdr = hdr;
      for (int c = 0; c < 4; c++) begin
        if (en[c]) begin
          v = directed ? 16'(base) : 16'($urandom_range(1, 65535));
          base++;
          lanes.push_back(v);
          e.d[16*c +: 16] = v;
        end
      end
      if (expect_out) exp_q.push_back(e);
    end
    while (lanes.size() % 4 != 0) lanes.push_back(16'd0);
    for (int w = 0; w < lanes.size() / 4; w++) begin
      up_q.push_back({lanes[4*w+3], lanes[4*w+2],
                      lanes[4*w+1], lanes[4*w]});
    end
  endtask

  task automatic strobe();
    fifo_rd_en = 1'b1;
    timestamp = ts;
    ts_q.push_back(ts);
    @(posedge clk);
    #1;
    ts++;
    fifo_rd_en = 1'b0;
    timestamp = ts;
  endtask

  task automatic run_until_empty(input int budget, input int stall_at,
                                 input int stall_len);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (stall_at >= 0)
        stall = (ts >= 64'(stall_at)) && (ts < 64'(stall_at + stall_len));
      strobe();
      n++;
    end
    stall = 1'b0;
    check("frames_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("strobes_answered", 64'(ts_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, uf0, ev;
    logic [63:0] h;

    // wait until ts=20, then two sets and a trailing underflow
    do_reset(4'b1111, 2);
    ts = 0;
    base = 1;
    add_frame(64'd20, 1'b1, 1'b1, base);
    run_until_empty(200, -1, 0);
    check("t1_tail_underflow", 64'(last_uf), 64'd1);

    // three enabled channels, sets straddle words
    do_reset(4'b0111, 4);
    ts = 100;
    base = 1;
    add_frame(64'd110, 1'b1, 1'b1, base);
    run_until_empty(200, -1, 0);

    // late frame dropped, following frame still parsed
    do_reset(4'b1111, 2);
    ts = 10;
    timestamp = ts;
    late_hi = 0;
    add_frame(64'd5, 1'b0, 1'b0, base);
    add_frame(64'd30, 1'b1, 1'b0, base);
    repeat (12) @(posedge clk);
    #1;
    check("t3_late_count", 64'(late_count), 64'd1);
    check("t3_late_pulse_width", 64'(late_hi), 64'd1);
    run_until_empty(200, -1, 0);

    // immediate frame with one pad lane, then a timed frame
    do_reset(4'b0001, 3);
    ts = 0;
    add_frame(all_ones, 1'b1, 1'b0, base);
    add_frame(64'd15, 1'b1, 1'b0, base);
    run_until_empty(200, -1, 0);

    // upstream stall in the middle of a frame
    do_reset(4'b1111, 6);
    ts = 0;
    uf0 = uf_mid;
    add_frame(64'd10, 1'b1, 1'b0, base);
    run_until_empty(200, 11, 6);
    check("t5_stall_underflow", 64'(uf_mid > uf0), 64'd1);

    // reset in the middle of a frame
    do_reset(4'b1111, 8);
    ts = 0;
    add_frame(64'd5, 1'b1, 1'b0, base);
    for (int i = 0; i < 9; i++) strobe();
    reset = 1'b1;
    #1;
    check("t6_valid_cleared", 64'(fifo_rd_valid), 64'd0);
    check("t6_data_cleared", {fifo_rd_data_3, fifo_rd_data_2,
                              fifo_rd_data_1, fifo_rd_data_0}, 64'd0);
    check("t6_packed_rd_en", 64'(packed_fifo_rd_en), 64'd1);
    do_reset(4'b1111, 2);
    ts = 0;
    add_frame(64'd12, 1'b1, 1'b0, base);
    run_until_empty(200, -1, 0);

    // randomized configurations with bursty upstream
    for (int cfg = 0; cfg < 6; cfg++) begin
      do_reset(4'($urandom_range(1, 15)), int'($urandom_range(0, 5)));
      valid_pct = 70;
      ev = (timestamp_every == 0) ? 1 : int'(timestamp_every);
      ts = 64'($urandom_range(0, 1000));
      h = ts + 20;
      for (int f = 0; f < 4; f++) begin
        if (f == 1 && cfg % 2 == 1) begin
          add_frame(all_ones, 1'b1, 1'b0, base);
        end else begin
          add_frame(h, 1'b1, 1'b0, base);
        end
        h = h + 64'(8 * ev + 40);
      end
      run_until_empty(3000, -1, 0);
      check("rand_no_late", 64'(late_count), 64'd0);
      valid_pct = 100;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
